// File: rtl/ex_stage_reg_pkg.sv
// Instruction ID constants shared by the decode, hazard and execute stages of the P7 core,
// plus the HI/LO-class decode used by every unit that arbitrates for the mult/div unit.
package ex_stage_reg_pkg;

  localparam int ID_W = 11;
  typedef logic [ID_W-1:0] instr_id_t;

  localparam instr_id_t ID_NOP   = 11'd0;
  localparam instr_id_t ID_ADDU  = 11'd1;
  localparam instr_id_t ID_OR    = 11'd2;
  localparam instr_id_t ID_ADD   = 11'd3;
  localparam instr_id_t ID_MULT  = 11'd8;
  localparam instr_id_t ID_MULTU = 11'd9;
  localparam instr_id_t ID_DIV   = 11'd10;
  localparam instr_id_t ID_DIVU  = 11'd11;
  localparam instr_id_t ID_MFHI  = 11'd12;
  localparam instr_id_t ID_MFLO  = 11'd13;
  localparam instr_id_t ID_MTHI  = 11'd14;
  localparam instr_id_t ID_MTLO  = 11'd15;

  // True for every instruction that starts the mult/div unit or touches HI/LO.
  function automatic logic is_md_class(input instr_id_t id);
    logic r;
    r = 1'b0;
    case (id)
      ID_MULT, ID_MULTU, ID_DIV, ID_DIVU,
      ID_MFHI, ID_MFLO, ID_MTHI, ID_MTLO: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_reg.sv
// D->E pipeline register: owns the mult/div structural-hazard stall, CP0 flush of E,
// and a saturating count of cycles lost to the mult/div hazard.
module ex_stage_reg
  import ex_stage_reg_pkg::*;
#(
  parameter instr_id_t   NOP_ID   = ID_NOP,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ID_W-1:0]  d_instr_id,
  input  logic [31:0]      d_pc,
  input  logic [31:0]      d_rs_val,
  input  logic [31:0]      d_rt_val,
  input  logic [31:0]      d_imm,
  input  logic [4:0]       d_wr_addr,
  input  logic             d_is_bd,
  input  logic [4:0]       d_exc_code,
  input  logic             other_stall,
  input  logic             md_busy,
  input  logic             md_start,
  input  logic             flush,
  output logic [ID_W-1:0]  e_instr_id,
  output logic [31:0]      e_pc,
  output logic [31:0]      e_a,
  output logic [31:0]      e_b,
  output logic [31:0]      e_imm,
  output logic [4:0]       e_wr_addr,
  output logic             e_is_bd,
  output logic [4:0]       e_exc_code,
  output logic             e_valid,
  output logic             d_stall,
  output logic [CNT_W-1:0] md_stall_cnt
);

  logic w_md_class;
  logic w_md_hazard;
  logic w_d_stall;

  instr_id_t        r_instr_id;
  logic [31:0]      r_pc;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_imm;
  logic [4:0]       r_wr_addr;
  logic             r_is_bd;
  logic [4:0]       r_exc_code;
  logic             r_valid;
  logic [CNT_W-1:0] r_md_stall_cnt;

  assign w_md_class  = is_md_class(d_instr_id);
  assign w_md_hazard = w_md_class & (md_busy | md_start);
  // A flush must let F/D take the handler fetch, so it overrides any stall.
  assign w_d_stall   = (w_md_hazard | other_stall) & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_id <= NOP_ID;
      r_pc       <= RESET_PC;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_wr_addr  <= '0;
      r_is_bd    <= 1'b0;
      r_exc_code <= '0;
      r_valid    <= 1'b0;
    end else if (flush) begin
      r_instr_id <= NOP_ID;
      r_pc       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_wr_addr  <= '0;
      r_is_bd    <= 1'b0;
      r_exc_code <= '0;
      r_valid    <= 1'b0;
    end else if (w_d_stall) begin
      // The bubble keeps the stalled instruction's PC and delay-slot flag so an
      // interrupt taken on the bubble still yields the right EPC.
      r_instr_id <= NOP_ID;
      r_pc       <= d_pc;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_wr_addr  <= '0;
      r_is_bd    <= d_is_bd;
      r_exc_code <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_instr_id <= d_instr_id;
      r_pc       <= d_pc;
      r_a        <= d_rs_val;
      r_b        <= d_rt_val;
      r_imm      <= d_imm;
      r_wr_addr  <= d_wr_addr;
      r_is_bd    <= d_is_bd;
      r_exc_code <= d_exc_code;
      r_valid    <= 1'b1;
    end
  end

  // Counts mult/div hazard cycles only; load-use stalls are not attributed here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_stall_cnt <= '0;
    end else if (w_md_hazard && !flush && (r_md_stall_cnt != {CNT_W{1'b1}})) begin
      r_md_stall_cnt <= r_md_stall_cnt + CNT_W'(1);
    end
  end

  assign e_instr_id   = r_instr_id;
  assign e_pc         = r_pc;
  assign e_a          = r_a;
  assign e_b          = r_b;
  assign e_imm        = r_imm;
  assign e_wr_addr    = r_wr_addr;
  assign e_is_bd      = r_is_bd;
  assign e_exc_code   = r_exc_code;
  assign e_valid      = r_valid;
  assign d_stall      = w_d_stall;
  assign md_stall_cnt = r_md_stall_cnt;

endmodule

// File: tb/tb_ex_stage_reg.sv
// Bench for ex_stage_reg: a 32-bit-counter instance and a 4-bit-counter instance share one
// set of inputs; directed vectors plus hand-written multi-cycle sequences.
module tb_ex_stage_reg;
  import ex_stage_reg_pkg::*;

  logic        clk;
  logic        reset;
  logic [10:0] d_instr_id;
  logic [31:0] d_pc, d_rs_val, d_rt_val, d_imm;
  logic [4:0]  d_wr_addr;
  logic        d_is_bd;
  logic [4:0]  d_exc_code;
  logic        other_stall, md_busy, md_start, flush;

  logic [10:0] e_instr_id, e4_instr_id;
  logic [31:0] e_pc, e_a, e_b, e_imm, e4_pc, e4_a, e4_b, e4_imm;
  logic [4:0]  e_wr_addr, e_exc_code, e4_wr_addr, e4_exc_code;
  logic        e_is_bd, e_valid, d_stall, e4_is_bd, e4_valid, d4_stall;
  logic [31:0] md_stall_cnt;
  logic [3:0]  md_stall_cnt4;

  int n_total = 0;
  int n_bad   = 0;
  logic [10:0] exp_q[$];

  ex_stage_reg dut (
    .clk(clk), .reset(reset), .d_instr_id(d_instr_id), .d_pc(d_pc),
    .d_rs_val(d_rs_val), .d_rt_val(d_rt_val), .d_imm(d_imm), .d_wr_addr(d_wr_addr),
    .d_is_bd(d_is_bd), .d_exc_code(d_exc_code), .other_stall(other_stall),
    .md_busy(md_busy), .md_start(md_start), .flush(flush),
    .e_instr_id(e_instr_id), .e_pc(e_pc), .e_a(e_a), .e_b(e_b), .e_imm(e_imm),
    .e_wr_addr(e_wr_addr), .e_is_bd(e_is_bd), .e_exc_code(e_exc_code),
    .e_valid(e_valid), .d_stall(d_stall), .md_stall_cnt(md_stall_cnt)
  );

  ex_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .d_instr_id(d_instr_id), .d_pc(d_pc),
    .d_rs_val(d_rs_val), .d_rt_val(d_rt_val), .d_imm(d_imm), .d_wr_addr(d_wr_addr),
    .d_is_bd(d_is_bd), .d_exc_code(d_exc_code), .other_stall(other_stall),
    .md_busy(md_busy), .md_start(md_start), .flush(flush),
    .e_instr_id(e4_instr_id), .e_pc(e4_pc), .e_a(e4_a), .e_b(e4_b), .e_imm(e4_imm),
    .e_wr_addr(e4_wr_addr), .e_is_bd(e4_is_bd), .e_exc_code(e4_exc_code),
    .e_valid(e4_valid), .d_stall(d4_stall), .md_stall_cnt(md_stall_cnt4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [10:0] id;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  wr;
    logic        bd;
    logic [4:0]  exc;
    logic        os, busy, start, fl;
    logic        x_stall;
    logic [10:0] x_id;
    logic [31:0] x_pc;
    logic        x_valid;
    logic [4:0]  x_wr;
    logic        x_bd;
    logic [4:0]  x_exc;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [10:0] id, input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] wr,
                         input logic bd, input logic [4:0] exc);
    d_instr_id = id; d_pc = pc; d_rs_val = rs; d_rt_val = rt;
    d_imm = imm; d_wr_addr = wr; d_is_bd = bd; d_exc_code = exc;
  endtask

  task automatic drive_ctl(input logic os, input logic busy, input logic start, input logic fl);
    other_stall = os; md_busy = busy; md_start = start; flush = fl;
  endtask

  initial begin
    // Counter column: hazard cycles accumulated since reset (both counters stay below 15 here).
    vecs[0]  = '{"addu_idle",      ID_ADDU, 32'h3000, 32'd11, 32'd22, 32'd33, 5'd3, 1'b0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, ID_ADDU, 32'h3000, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0};
    vecs[1]  = '{"addu_md_busy",   ID_ADDU, 32'h3010, 32'd44, 32'd55, 32'd66, 5'd4, 1'b0, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b0,  1'b0, ID_ADDU, 32'h3010, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0};
    vecs[2]  = '{"mtlo_bd_flush",  ID_MTLO, 32'h3024, 32'd1,  32'd2,  32'd3,  5'd0, 1'b1, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b1,  1'b0, ID_NOP,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd0};
    vecs[3]  = '{"or_other_stall", ID_OR,   32'h3030, 32'd7,  32'd8,  32'd9,  5'd5, 1'b0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, ID_NOP,  32'h3030, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0};
    vecs[4]  = '{"or_release",     ID_OR,   32'h3030, 32'd7,  32'd8,  32'd9,  5'd5, 1'b0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, ID_OR,   32'h3030, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0};
    vecs[5]  = '{"add_exc_r0",     ID_ADD,  32'h3034, 32'hA5A5_0000, 32'h0000_5A5A, 32'hFFFF_FFFF,
                 5'd0, 1'b1, 5'd12,
                 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, ID_ADD,  32'h3034, 1'b1, 5'd0, 1'b1, 5'd12, 32'd0};
    vecs[6]  = '{"mult_md_start",  ID_MULT, 32'h3038, 32'd3,  32'd4,  32'd0,  5'd0, 1'b1, 5'd0,
                 1'b0, 1'b0, 1'b1, 1'b0,  1'b1, ID_NOP,  32'h3038, 1'b0, 5'd0, 1'b1, 5'd0, 32'd1};
    vecs[7]  = '{"mflo_start_os",  ID_MFLO, 32'h303C, 32'd0,  32'd0,  32'd0,  5'd6, 1'b0, 5'd3,
                 1'b1, 1'b0, 1'b1, 1'b0,  1'b1, ID_NOP,  32'h303C, 1'b0, 5'd0, 1'b0, 5'd0, 32'd2};
    vecs[8]  = '{"mfhi_flush_all", ID_MFHI, 32'h3040, 32'd0,  32'd0,  32'd0,  5'd7, 1'b1, 5'd0,
                 1'b1, 1'b1, 1'b0, 1'b1,  1'b0, ID_NOP,  32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 32'd2};
    vecs[9]  = '{"mthi_free",      ID_MTHI, 32'h3044, 32'd9,  32'd0,  32'd0,  5'd0, 1'b0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, ID_MTHI, 32'h3044, 1'b1, 5'd0, 1'b0, 5'd0, 32'd2};
    vecs[10] = '{"or_md_start",    ID_OR,   32'h3048, 32'd1,  32'd2,  32'd3,  5'd9, 1'b0, 5'd0,
                 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, ID_OR,   32'h3048, 1'b1, 5'd9, 1'b0, 5'd0, 32'd2};
    vecs[11] = '{"divu_busy",      ID_DIVU, 32'h304C, 32'd5,  32'd6,  32'd0,  5'd0, 1'b0, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b0,  1'b1, ID_NOP,  32'h304C, 1'b0, 5'd0, 1'b0, 5'd0, 32'd3};

    // Reset held two cycles with random D fields.
    reset = 1'b1;
    drive_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    drive_d(11'($urandom_range(0, 2047)), $urandom, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    step();
    step();
    check("rst_e_id",    32'(e_instr_id), 32'(ID_NOP));
    check("rst_e_pc",    e_pc, 32'h0000_3000);
    check("rst_e_valid", 32'(e_valid), 32'd0);
    check("rst_cnt",     md_stall_cnt, 32'd0);
    check("rst_cnt4",    32'(md_stall_cnt4), 32'd0);
    check("rst_d_stall", 32'(d_stall), 32'd0);
    reset = 1'b0;

    // Table-driven vectors: d_stall before the edge, E fields and counters after it.
    for (int i = 0; i < 12; i++) begin
      drive_d(vecs[i].id, vecs[i].pc, vecs[i].rs, vecs[i].rt, vecs[i].imm,
              vecs[i].wr, vecs[i].bd, vecs[i].exc);
      drive_ctl(vecs[i].os, vecs[i].busy, vecs[i].start, vecs[i].fl);
      #1;
      check({vecs[i].name, ".d_stall"}, 32'(d_stall), 32'(vecs[i].x_stall));
      step();
      check({vecs[i].name, ".e_id"},    32'(e_instr_id), 32'(vecs[i].x_id));
      check({vecs[i].name, ".e_pc"},    e_pc, vecs[i].x_pc);
      check({vecs[i].name, ".e_valid"}, 32'(e_valid), 32'(vecs[i].x_valid));
      check({vecs[i].name, ".e_wr"},    32'(e_wr_addr), 32'(vecs[i].x_wr));
      check({vecs[i].name, ".e_bd"},    32'(e_is_bd), 32'(vecs[i].x_bd));
      check({vecs[i].name, ".e_exc"},   32'(e_exc_code), 32'(vecs[i].x_exc));
      check({vecs[i].name, ".cnt"},     md_stall_cnt, vecs[i].x_cnt);
      check({vecs[i].name, ".cnt4"},    32'(md_stall_cnt4), vecs[i].x_cnt);
      if (vecs[i].x_valid) begin
        check({vecs[i].name, ".e_a"},   e_a, vecs[i].rs);
        check({vecs[i].name, ".e_b"},   e_b, vecs[i].rt);
        check({vecs[i].name, ".e_imm"}, e_imm, vecs[i].imm);
      end
    end

    // div in E: md_start for one cycle, then md_busy for 10; mfhi waits in D.
    drive_d(ID_MFHI, 32'h3050, 32'd0, 32'd0, 32'd0, 5'd8, 1'b0, 5'd0);
    for (int c = 0; c < 12; c++) begin
      drive_ctl(1'b0, (c >= 1 && c <= 10), (c == 0), 1'b0);
      exp_q.push_back((c < 11) ? ID_NOP : ID_MFHI);
      #1;
      check($sformatf("div_mfhi.d_stall[%0d]", c), 32'(d_stall), (c < 11) ? 32'd1 : 32'd0);
      step();
      check($sformatf("div_mfhi.e_id[%0d]", c), 32'(e_instr_id), 32'(exp_q.pop_front()));
      check($sformatf("div_mfhi.e_pc[%0d]", c), e_pc, 32'h3050);
    end
    check("div_mfhi.e_valid", 32'(e_valid), 32'd1);
    check("div_mfhi.e_wr",    32'(e_wr_addr), 32'd8);
    check("div_mfhi.cnt",     md_stall_cnt, 32'd14);
    check("div_mfhi.cnt4",    32'(md_stall_cnt4), 32'd14);

    // Reset lands mid-stall; the mult/div unit drops busy with the same reset.
    drive_d(ID_MFLO, 32'h3060, 32'd0, 32'd0, 32'd0, 5'd2, 1'b0, 5'd0);
    drive_ctl(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("mid_stall.cnt_before", md_stall_cnt, 32'd15);
    reset = 1'b1;
    md_busy = 1'b0;
    step();
    reset = 1'b0;
    check("mid_reset.e_id",    32'(e_instr_id), 32'(ID_NOP));
    check("mid_reset.e_pc",    e_pc, 32'h0000_3000);
    check("mid_reset.e_valid", 32'(e_valid), 32'd0);
    check("mid_reset.cnt",     md_stall_cnt, 32'd0);
    check("mid_reset.cnt4",    32'(md_stall_cnt4), 32'd0);

    // 20 hazard cycles: the 4-bit counter pins at 4'hF, the 32-bit one keeps counting.
    drive_d(ID_MULT, 32'h3070, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
    drive_ctl(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 14) check("sat.cnt4_at_15", 32'(md_stall_cnt4), 32'd15);
    end
    check("sat.cnt4", 32'(md_stall_cnt4), 32'd15);
    check("sat.cnt",  md_stall_cnt, 32'd20);
    md_busy = 1'b0;
    step();
    check("sat.release_e_id", 32'(e_instr_id), 32'(ID_MULT));
    check("sat.cnt4_hold",    32'(md_stall_cnt4), 32'd15);

    // Final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage_reg.md
Name: ex_stage_reg

Overview:
- D→E pipeline register of the P7 MIPS core. It feeds the multiply/divide unit and the ALU with the E-stage instruction ID and operands.
- Owns the mult/div structural-hazard stall. A D-stage instruction that touches HI/LO is frozen in D while the mult/div unit is busy or starting; a bubble goes into E meanwhile.
- Handles interrupt/exception flush of E and keeps a saturating md-stall performance counter.

Parameters:
- NOP_ID, 11'd0, instruction ID written into E for a bubble.
- RESET_PC, 32'h0000_3000, e_pc value after reset.
- CNT_W, 32, width of the md-stall performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- d_instr_id  in  11  decoded instruction ID in D (shared ID constants).
- d_pc  in  32  PC of the D instruction.
- d_rs_val  in  32  forwarded rs value.
- d_rt_val  in  32  forwarded rt value.
- d_imm  in  32  extended immediate.
- d_wr_addr  in  5  destination GPR (0 = none).
- d_is_bd  in  1  D instruction is in a branch delay slot.
- d_exc_code  in  5  exception code raised in F/D (0 = none).
- other_stall  in  1  load-use/forwarding stall from the hazard unit.
- md_busy  in  1  busy from the mult/div unit.
- md_start  in  1  start from the mult/div unit (E instruction is mult/multu/div/divu).
- flush  in  1  interrupt/exception/eret flush request from CP0.
- e_instr_id  out  11  E instruction ID (to the mult/div unit, ALU).
- e_pc  out  32  E PC.
- e_a  out  32  E rs value.
- e_b  out  32  E rt value.
- e_imm  out  32  E immediate.
- e_wr_addr  out  5  E destination.
- e_is_bd  out  1  E delay-slot flag.
- e_exc_code  out  5  E exception code.
- e_valid  out  1  0 when E holds a bubble.
- d_stall  out  1  freeze PC and F/D register (combinational).
- md_stall_cnt  out  CNT_W  cycles stalled on the mult/div hazard.

Behaviour:
- md_class = d_instr_id ∈ {mult, multu, div, divu, mfhi, mflo, mthi, mtlo}.
- md_hazard = md_class & (md_busy | md_start). Combinational, no registered delay.
- d_stall = (md_hazard | other_stall) & ~flush.
- Register update priority each posedge, highest first:
  - reset: all outputs 0 except e_pc = RESET_PC and e_instr_id = NOP_ID; e_valid = 0; md_stall_cnt = 0.
  - flush: bubble with e_instr_id = NOP_ID, e_valid = 0, e_exc_code = 0, e_wr_addr = 0, e_is_bd = 0, e_pc = 0.
  - d_stall: bubble with e_instr_id = NOP_ID, e_valid = 0, e_wr_addr = 0, e_exc_code = 0. e_pc ← d_pc and e_is_bd ← d_is_bd, so CP0 computes the correct EPC if an interrupt lands on the bubble.
  - otherwise: load all d_* fields; e_valid = 1.
- Latency: one cycle from D to E.
- A non-md instruction never stalls on md_busy. Example: an add during a 10-cycle div issues with no stall.
- Back-to-back mult then mflo:
  - cycle where mult is in E: md_start = 1 stalls mflo.
  - following cycles: md_busy stalls mflo.
  - mflo enters E on the first edge after md_busy falls.
- md_stall_cnt increments by 1 on each edge where md_hazard & ~flush & ~reset. It saturates at all-ones. other_stall alone does not count.
- Reset mid-stall: E becomes NOP at RESET_PC and the counter clears. The mult/div unit is reset by the same signal.
- Flush and stall in the same cycle: flush wins and d_stall is forced 0, letting F/D take the handler fetch.
- Zero-register writes pass through unchanged; filtering is downstream.

Decomposition:
- Instruction ID constants (nop, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, …) and the 11-bit ID width live in the shared lib include.
- md_class decode is a function in that shared include, also reused by the hazard unit.
- No sub-module needed; one register process plus combinational stall/counter logic.

Test Plan:
- Reset held 2 cycles with random d_* → e_instr_id = NOP_ID, e_pc = 32'h0000_3000, e_valid = 0, md_stall_cnt = 0, d_stall = 0.
- div in E (md_start = 1, then md_busy = 1 for 10 cycles) with mfhi in D → d_stall = 1 for 11 cycles, 11 bubbles carrying mfhi's PC, mfhi in E on cycle 12, md_stall_cnt = 11.
- multu running (md_busy = 1), D = addu pc 0x3010 → no stall; e_instr_id = addu, e_pc = 0x3010 next edge.
- md_busy = 1, D = mtlo in delay slot (d_is_bd = 1, pc 0x3024), flush asserted → E bubble with e_pc = 0, e_is_bd = 0, d_stall = 0, counter unchanged.
- other_stall = 1 with D = or → bubble inserted, md_stall_cnt unchanged; release → or enters E.
- Preload counter near saturation (CNT_W = 4 build) with 20 md-hazard cycles → md_stall_cnt holds 4'hF.
